// File: rtl/idm_arbiter_pkg.sv
// Shared encodings for the IDM arbiter: FSM states, owner codes and default
// memory geometry used by the datapath and control unit.
package idm_arbiter_pkg;

    localparam int IDM_ADDR_W = 8;
    localparam int IDM_DATA_W = 16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CPU_A = 3'd1;
    localparam logic [2:0] ST_CPU_D = 3'd2;
    localparam logic [2:0] ST_EXT_A = 3'd3;
    localparam logic [2:0] ST_EXT_D = 3'd4;

    localparam logic [1:0] OWN_IDLE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_EXT  = 2'b10;

    function automatic logic [1:0] owner_of(input logic [2:0] st);
        case (st)
            ST_CPU_A, ST_CPU_D: return OWN_CPU;
            ST_EXT_A, ST_EXT_D: return OWN_EXT;
            default:            return OWN_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/idm_wait_counter.sv
// Saturating starvation counter for the EXT port; at_limit_o tells the
// arbiter that EXT has waited long enough to be forced ahead of the CPU.
module idm_wait_counter #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_limit_o
);

    localparam logic [3:0] MAX_L = 4'(MAX_WAIT);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q < MAX_L))
            cnt_d = cnt_q + 4'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign at_limit_o = (cnt_q >= MAX_L);

endmodule

// File: rtl/idm_arbiter.sv
// Two-port arbiter for the single-port IDM: CPU-first priority, bounded EXT
// wait, and a two-cycle address/data sequence per access.
module idm_arbiter
    import idm_arbiter_pkg::*;
#(
    parameter int ADDR_W   = IDM_ADDR_W,
    parameter int DATA_W   = IDM_DATA_W,
    parameter int MAX_WAIT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              cpu_halted,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        owner
);

    logic [2:0]        state_q, state_d, arb_st;
    logic              acc_we_q, acc_we_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic              ext_rvalid_q, ext_rvalid_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;
    logic              ext_at_limit;

    idm_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait (
        .clk_i      (CLK),
        .rst_i      (RST),
        .inc_i      (ext_req & ~ext_gnt),
        .clr_i      (ext_gnt | ~ext_req),
        .at_limit_o (ext_at_limit)
    );

    always_comb begin
        arb_st = ST_IDLE;
        if (cpu_halted && ext_req)        arb_st = ST_EXT_A;
        else if (ext_req && ext_at_limit) arb_st = ST_EXT_A;
        else if (cpu_req)                 arb_st = ST_CPU_A;
        else if (ext_req)                 arb_st = ST_EXT_A;
    end

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_CPU_A: state_d = ST_CPU_D;
            ST_EXT_A: state_d = ST_EXT_D;
            default:  state_d = arb_st;
        endcase
    end

    assign cpu_gnt   = (state_q == ST_CPU_A);
    assign ext_gnt   = (state_q == ST_EXT_A);
    assign cpu_stall = cpu_req & ~cpu_gnt;
    assign owner     = owner_of(state_q);

    // Address-phase signals pass straight from the owning port; zero otherwise.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (ext_gnt) begin
            mem_en    = 1'b1;
            mem_we    = ext_we;
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
        end
    end

    // The requester may drop its fields after gnt, so remember the access type.
    always_comb begin
        acc_we_d     = mem_en ? mem_we : acc_we_q;
        cpu_rvalid_d = (state_q == ST_CPU_D);
        ext_rvalid_d = (state_q == ST_EXT_D);
        cpu_rdata_d  = cpu_rdata_q;
        ext_rdata_d  = ext_rdata_q;
        if ((state_q == ST_CPU_D) && !acc_we_q) cpu_rdata_d = mem_rdata;
        if ((state_q == ST_EXT_D) && !acc_we_q) ext_rdata_d = mem_rdata;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            acc_we_q     <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            ext_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            ext_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            acc_we_q     <= acc_we_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            ext_rvalid_q <= ext_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            ext_rdata_q  <= ext_rdata_d;
        end
    end

    assign cpu_rvalid = cpu_rvalid_q;
    assign ext_rvalid = ext_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign ext_rdata  = ext_rdata_q;

endmodule

// File: tb/tb_idm_arbiter.sv
// Bench for idm_arbiter: directed scenarios plus random two-port traffic,
// checked every cycle against a transaction-level reference model.
module tb_idm_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int MW = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          cpu_req, cpu_we, cpu_halted;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          ext_req, ext_we;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata;
    logic          cpu_gnt, cpu_rvalid, cpu_stall, ext_gnt, ext_rvalid;
    logic [DW-1:0] cpu_rdata, ext_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [1:0]    owner;

    always #5 CLK = ~CLK;

    idm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .CLK(CLK), .RST(RST),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall), .cpu_halted(cpu_halted),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner)
    );

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return (a == 8'h10) ? 16'hBEEF : {a, ~a};
    endfunction

    // Synchronous single-port IDM: read data appears the cycle after mem_en.
    logic [DW-1:0] bmem [256];
    bit            bw   [256];
    always @(posedge CLK) begin
        if (mem_en === 1'b1) begin
            if (mem_we) begin
                bmem[mem_addr] <= mem_wdata;
                bw[mem_addr]   <= 1'b1;
            end
            mem_rdata <= bw[mem_addr] ? bmem[mem_addr] : init_val(mem_addr);
        end
    end

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: who owns the memory, which half of the access, and
    // how long EXT has been kept waiting.
    int            m_own;
    bit            m_d;
    int            m_wait;
    bit            m_we;
    logic [DW-1:0] m_rdval;
    logic [DW-1:0] mm [256];
    bit            e_cpu_rv, e_ext_rv;
    logic [DW-1:0] e_cpu_rd, e_ext_rd;
    bit            eg_cpu, eg_ext;
    int            ext_age;

    function automatic int arb_pick();
        if (cpu_halted && ext_req)  return 2;
        if (ext_req && m_wait >= MW) return 2;
        if (cpu_req)                return 1;
        if (ext_req)                return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_own = 0; m_d = 0; m_wait = 0; m_we = 0;
        e_cpu_rv = 0; e_ext_rv = 0; e_cpu_rd = '0; e_ext_rd = '0;
        ext_age = 0;
    endtask

    task automatic at_neg();
        bit            a_ph;
        logic          x_we;
        logic [AW-1:0] x_addr;
        logic [DW-1:0] x_wd;
        @(negedge CLK);
        a_ph   = (m_own != 0) && !m_d;
        eg_cpu = a_ph && (m_own == 1);
        eg_ext = a_ph && (m_own == 2);
        x_we   = eg_cpu ? cpu_we   : eg_ext ? ext_we   : 1'b0;
        x_addr = eg_cpu ? cpu_addr : eg_ext ? ext_addr : '0;
        x_wd   = eg_cpu ? cpu_wdata: eg_ext ? ext_wdata: '0;
        chk("cpu_gnt",    32'(cpu_gnt),    32'(eg_cpu));
        chk("ext_gnt",    32'(ext_gnt),    32'(eg_ext));
        chk("cpu_stall",  32'(cpu_stall),  32'(cpu_req & ~eg_cpu));
        chk("mem_en",     32'(mem_en),     32'(a_ph));
        chk("mem_we",     32'(mem_we),     32'(x_we));
        chk("mem_addr",   32'(mem_addr),   32'(x_addr));
        chk("mem_wdata",  32'(mem_wdata),  32'(x_wd));
        chk("owner",      32'(owner),      32'(m_own));
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(e_cpu_rv));
        chk("ext_rvalid", 32'(ext_rvalid), 32'(e_ext_rv));
        chk("cpu_rdata",  32'(cpu_rdata),  32'(e_cpu_rd));
        chk("ext_rdata",  32'(ext_rdata),  32'(e_ext_rd));
        if (eg_ext) chk("ext_wait_bound", 32'(ext_age <= MW + 2), 1);
    endtask

    task automatic clk_edge();
        int            nxt_own, nw;
        logic [AW-1:0] a;
        @(posedge CLK);
        if (m_own != 0 && !m_d) begin
            a    = (m_own == 1) ? cpu_addr : ext_addr;
            m_we = (m_own == 1) ? cpu_we   : ext_we;
            if (m_we) mm[a] = (m_own == 1) ? cpu_wdata : ext_wdata;
            else      m_rdval = mm[a];
        end
        if (RST) begin
            model_reset();
        end else begin
            e_cpu_rv = (m_own == 1) && m_d;
            e_ext_rv = (m_own == 2) && m_d;
            if (e_cpu_rv && !m_we) e_cpu_rd = m_rdval;
            if (e_ext_rv && !m_we) e_ext_rd = m_rdval;
            nw = (ext_req && !eg_ext) ? ((m_wait + 1 > MW) ? MW : m_wait + 1) : 0;
            if (m_own != 0 && !m_d) m_d = 1;
            else begin
                nxt_own = arb_pick();
                m_own = nxt_own;
                m_d = 0;
            end
            m_wait  = nw;
            ext_age = (ext_req && !eg_ext) ? ext_age + 1 : 0;
        end
        #1;
    endtask

    task automatic tick();
        at_neg();
        clk_edge();
    endtask

    task automatic cpu_set(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic ext_set(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ext_req = r; ext_we = w; ext_addr = a; ext_wdata = d;
    endtask

    initial begin
        int lat;
        bit cpu_pend, ext_pend;
        for (int i = 0; i < 256; i++) mm[i] = init_val(8'(i));
        model_reset();
        eg_cpu = 0; eg_ext = 0;
        RST = 1'b1; cpu_halted = 1'b0;
        cpu_set(0, 0, '0, '0);
        ext_set(0, 0, '0, '0);
        @(posedge CLK); #1;

        // Reset state
        at_neg();
        chk("rst_owner",    32'(owner),    0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_rdata",    32'(cpu_rdata), 0);
        clk_edge();
        RST = 1'b0;
        tick();

        // CPU read alone
        cpu_set(1, 0, 8'h10, '0);
        at_neg(); chk("t1_stall", 32'(cpu_stall), 1); clk_edge();
        at_neg(); chk("t1_gnt", 32'(cpu_gnt), 1); chk("t1_en", 32'(mem_en), 1);
        chk("t1_addr", 32'(mem_addr), 32'h10); clk_edge();
        cpu_set(0, 0, 8'h10, '0);
        tick();
        at_neg(); chk("t1_rvalid", 32'(cpu_rvalid), 1); chk("t1_rdata", 32'(cpu_rdata), 32'hBEEF); clk_edge();
        at_neg(); chk("t1_rv_pulse", 32'(cpu_rvalid), 0); chk("t1_hold", 32'(cpu_rdata), 32'hBEEF); clk_edge();

        // EXT write then CPU read of the same address
        ext_set(1, 1, 8'h20, 16'h1234);
        tick();
        at_neg(); chk("t2_ext_gnt", 32'(ext_gnt), 1); chk("t2_we", 32'(mem_we), 1); clk_edge();
        ext_set(0, 0, 8'h20, '0);
        tick();
        at_neg(); chk("t2_ext_rv", 32'(ext_rvalid), 1); chk("t2_ext_rd", 32'(ext_rdata), 0); clk_edge();
        cpu_set(1, 0, 8'h20, '0);
        at_neg(); chk("t2_ext_rv_once", 32'(ext_rvalid), 0); clk_edge();
        tick();
        cpu_set(0, 0, 8'h20, '0);
        tick();
        at_neg(); chk("t2_cpu_rd", 32'(cpu_rdata), 32'h1234); chk("t2_cpu_rv", 32'(cpu_rvalid), 1); clk_edge();

        // Starvation: CPU back-to-back, EXT raised during a CPU data cycle
        cpu_set(1, 0, 8'h05, '0);
        tick();
        tick();
        ext_set(1, 0, 8'h10, '0);
        lat = -1;
        for (int k = 0; k < 12; k++) begin
            at_neg();
            if (ext_gnt === 1'b1) begin
                lat = k;
                clk_edge();
                break;
            end
            clk_edge();
        end
        chk("starve_latency", 32'(lat), 5);
        ext_set(0, 0, 8'h10, '0);
        tick();
        at_neg(); chk("starve_cpu_back", 32'(cpu_gnt), 1); clk_edge();
        cpu_set(0, 0, 8'h05, '0);
        for (int k = 0; k < 3; k++) tick();

        // cpu_halted: EXT first, CPU stalls until its own grant
        ext_set(1, 0, 8'h20, '0);
        cpu_set(1, 0, 8'h21, '0);
        cpu_halted = 1'b1;
        at_neg(); chk("halt_stall0", 32'(cpu_stall), 1); clk_edge();
        at_neg(); chk("halt_ext_first", 32'(ext_gnt), 1); chk("halt_stall1", 32'(cpu_stall), 1); clk_edge();
        ext_set(0, 0, 8'h20, '0);
        at_neg(); chk("halt_stall2", 32'(cpu_stall), 1); clk_edge();
        at_neg(); chk("halt_cpu_gnt", 32'(cpu_gnt), 1); chk("halt_stall3", 32'(cpu_stall), 0); clk_edge();
        cpu_set(0, 0, 8'h21, '0);
        cpu_halted = 1'b0;
        for (int k = 0; k < 3; k++) tick();

        // Reset during CPU data cycle, then a fresh read
        cpu_set(1, 0, 8'h30, '0);
        tick();
        tick();
        cpu_set(0, 0, 8'h30, '0);
        RST = 1'b1;
        at_neg(); chk("rstd_owner_d", 32'(owner), 1); clk_edge();
        RST = 1'b0;
        at_neg(); chk("rstd_no_rv", 32'(cpu_rvalid), 0); chk("rstd_owner", 32'(owner), 0);
        chk("rstd_cpu_rd", 32'(cpu_rdata), 0); chk("rstd_ext_rd", 32'(ext_rdata), 0); clk_edge();
        cpu_set(1, 0, 8'h30, '0);
        tick();
        at_neg(); chk("rstd_gnt", 32'(cpu_gnt), 1); clk_edge();
        cpu_set(0, 0, 8'h30, '0);
        tick();
        at_neg(); chk("rstd_rv", 32'(cpu_rvalid), 1); chk("rstd_rd", 32'(cpu_rdata), 32'h30CF); clk_edge();

        // Simultaneous requests from IDLE: owner 01,01,10,10,00
        cpu_set(1, 0, 8'h40, '0);
        ext_set(1, 1, 8'h41, 16'hCAFE);
        tick();
        at_neg(); chk("sim_own1", 32'(owner), 1); chk("sim_cpu_gnt", 32'(cpu_gnt), 1); clk_edge();
        cpu_set(0, 0, 8'h40, '0);
        at_neg(); chk("sim_own2", 32'(owner), 1); clk_edge();
        at_neg(); chk("sim_own3", 32'(owner), 2); chk("sim_ext_gnt", 32'(ext_gnt), 1); clk_edge();
        ext_set(0, 0, 8'h41, '0);
        at_neg(); chk("sim_own4", 32'(owner), 2); clk_edge();
        at_neg(); chk("sim_own5", 32'(owner), 0); clk_edge();

        // Random two-port traffic
        cpu_pend = 0; ext_pend = 0;
        for (int n = 0; n < 600; n++) begin
            if (cpu_pend && eg_cpu) cpu_pend = 0;
            if (ext_pend && eg_ext) ext_pend = 0;
            if (!cpu_pend) begin
                if ($urandom_range(0, 1) == 1) begin
                    cpu_set(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 16'($urandom));
                    cpu_pend = 1;
                end else cpu_req = 1'b0;
            end
            if (!ext_pend) begin
                if ($urandom_range(0, 2) == 0) begin
                    ext_set(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 16'($urandom));
                    ext_pend = 1;
                end else ext_req = 1'b0;
            end
            cpu_halted = ($urandom_range(0, 15) == 0);
            RST        = ($urandom_range(0, 99) == 0);
            tick();
        end
        RST = 1'b0;
        cpu_set(0, 0, '0, '0);
        ext_set(0, 0, '0, '0);
        for (int k = 0; k < 4; k++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
